// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM wishbone port between the Archimedes core master and the
// HPS ROM loader, with a one-word loader holding register and a bus watchdog.
module sdram_port_arbiter #(
   parameter logic [25:0] LOAD_BASE = 26'h0400000,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        core_cyc,
   input  logic        core_stb,
   input  logic        core_we,
   input  logic [3:0]  core_sel,
   input  logic [2:0]  core_cti,
   input  logic [25:0] core_adr,
   input  logic [31:0] core_dat,
   output logic        core_ack,
   input  logic        ld_active,
   input  logic        ld_wr,
   input  logic [24:0] ld_addr,
   input  logic [15:0] ld_data,
   output logic        ld_wait,
   output logic        ld_ovf,
   output logic        ram_cyc,
   output logic        ram_stb,
   output logic        ram_we,
   output logic [3:0]  ram_sel,
   output logic [25:0] ram_adr,
   output logic [31:0] ram_dat,
   output logic [2:0]  ram_cti,
   input  logic        ram_ack,
   output logic        timeout_err
);

   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, CORE, LOAD} state_t;

   state_t        state_q, state_d;
   logic          full_q, full_d;
   logic [25:0]   adr_q, adr_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   dat_q, dat_d;
   logic          ovf_q, ovf_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic          terr_q, terr_d;
   logic          wdogExpired;
   logic          unused_bits;

   assign unused_bits = ^{ld_addr[24], ld_addr[0], core_adr[1:0]};

   // Expires on the edge that would make the stalled-cycle count reach TIMEOUT.
   assign wdogExpired = (wdog_q == WW'(TIMEOUT - 1)) && !ram_ack;

   always_comb begin
      state_d = state_q;
      full_d  = full_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      dat_d   = dat_q;
      ovf_d   = ovf_q;
      wdog_d  = wdog_q;
      terr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (full_q)
               state_d = LOAD;
            else if (core_cyc && core_stb && !ld_active)
               state_d = CORE;
         end
         CORE: begin
            if (!core_cyc) begin
               state_d = IDLE;
               wdog_d  = '0;
            end else if (ram_ack) begin
               wdog_d = '0;
               if (core_cti == 3'b000 || core_cti == 3'b111)
                  state_d = IDLE;
            end else if (wdogExpired) begin
               state_d = IDLE;
               wdog_d  = '0;
               terr_d  = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         LOAD: begin
            if (ram_ack || wdogExpired) begin
               state_d = IDLE;
               full_d  = 1'b0;
               wdog_d  = '0;
               terr_d  = !ram_ack;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Capture decision uses the pre-edge full flag, so a word arriving on
      // the releasing edge is dropped and flagged rather than accepted.
      if (ld_wr) begin
         if (full_q) begin
            ovf_d = 1'b1;
         end else begin
            full_d = 1'b1;
            adr_d  = LOAD_BASE + {2'b00, ld_addr[23:2], 2'b00};
            sel_d  = ld_addr[1] ? 4'b1100 : 4'b0011;
            dat_d  = {ld_data, ld_data};
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         full_q  <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         ovf_q   <= 1'b0;
         wdog_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         full_q  <= full_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         ovf_q   <= ovf_d;
         wdog_q  <= wdog_d;
         terr_q  <= terr_d;
      end
   end

   assign ld_wait     = full_q;
   assign ld_ovf      = ovf_q;
   assign timeout_err = terr_q;

   // The granted master owns the bus; in IDLE everything is held at zero.
   always_comb begin
      ram_cyc  = 1'b0;
      ram_stb  = 1'b0;
      ram_we   = 1'b0;
      ram_sel  = '0;
      ram_adr  = '0;
      ram_dat  = '0;
      ram_cti  = '0;
      core_ack = 1'b0;
      case (state_q)
         CORE: begin
            ram_cyc  = core_cyc;
            ram_stb  = core_stb;
            ram_we   = core_we;
            ram_sel  = core_sel;
            ram_adr  = {core_adr[25:2], 2'b00};
            ram_dat  = core_dat;
            ram_cti  = core_cti;
            core_ack = ram_ack;
         end
         LOAD: begin
            ram_cyc = 1'b1;
            ram_stb = 1'b1;
            ram_we  = 1'b1;
            ram_sel = sel_q;
            ram_adr = adr_q;
            ram_dat = dat_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a bus-ownership reference model.
module tb_sdram_port_arbiter;

   localparam int          TO   = 16;
   localparam logic [25:0] BASE = 26'h0400000;
   localparam int NOBODY = 0, CORE_OWNS = 1, LOADER_OWNS = 2;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        core_cyc, core_stb, core_we;
   logic [3:0]  core_sel;
   logic [2:0]  core_cti;
   logic [25:0] core_adr;
   logic [31:0] core_dat;
   logic        core_ack;
   logic        ld_active, ld_wr;
   logic [24:0] ld_addr;
   logic [15:0] ld_data;
   logic        ld_wait, ld_ovf;
   logic        ram_cyc, ram_stb, ram_we;
   logic [3:0]  ram_sel;
   logic [25:0] ram_adr;
   logic [31:0] ram_dat;
   logic [2:0]  ram_cti;
   logic        ram_ack;
   logic        timeout_err;

   sdram_port_arbiter #(.LOAD_BASE(BASE), .TIMEOUT(TO)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we),
      .core_sel(core_sel), .core_cti(core_cti), .core_adr(core_adr),
      .core_dat(core_dat), .core_ack(core_ack),
      .ld_active(ld_active), .ld_wr(ld_wr), .ld_addr(ld_addr),
      .ld_data(ld_data), .ld_wait(ld_wait), .ld_ovf(ld_ovf),
      .ram_cyc(ram_cyc), .ram_stb(ram_stb), .ram_we(ram_we),
      .ram_sel(ram_sel), .ram_adr(ram_adr), .ram_dat(ram_dat),
      .ram_cti(ram_cti), .ram_ack(ram_ack), .timeout_err(timeout_err)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus, the pending loader word, stall count.
   int          owner;
   bit          pendValid;
   logic [25:0] pendAdr;
   logic [3:0]  pendSel;
   logic [31:0] pendDat;
   bit          ovfSeen;
   bit          abortPulse;
   int          waited;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, observed, expected);
      end
   endtask

   task automatic modelReset();
      owner      = NOBODY;
      pendValid  = 1'b0;
      pendAdr    = '0;
      pendSel    = '0;
      pendDat    = '0;
      ovfSeen    = 1'b0;
      abortPulse = 1'b0;
      waited     = 0;
   endtask

   task automatic modelStep();
      bit wasFull;
      wasFull    = pendValid;
      abortPulse = 1'b0;
      case (owner)
         NOBODY: begin
            waited = 0;
            if (pendValid) owner = LOADER_OWNS;
            else if (core_cyc && core_stb && !ld_active) owner = CORE_OWNS;
         end
         CORE_OWNS: begin
            if (!core_cyc) begin
               owner = NOBODY; waited = 0;
            end else if (ram_ack) begin
               waited = 0;
               if (core_cti == 3'b000 || core_cti == 3'b111) owner = NOBODY;
            end else begin
               waited++;
               if (waited == TO) begin abortPulse = 1'b1; owner = NOBODY; waited = 0; end
            end
         end
         default: begin
            if (ram_ack) begin
               pendValid = 1'b0; owner = NOBODY; waited = 0;
            end else begin
               waited++;
               if (waited == TO) begin
                  abortPulse = 1'b1; pendValid = 1'b0; owner = NOBODY; waited = 0;
               end
            end
         end
      endcase
      if (ld_wr) begin
         if (wasFull) ovfSeen = 1'b1;
         else begin
            pendValid = 1'b1;
            pendAdr   = BASE + 26'(ld_addr[23:0]) - 26'(ld_addr[1:0]);
            pendSel   = ld_addr[1] ? 4'b1100 : 4'b0011;
            pendDat   = {ld_data, ld_data};
         end
      end
   endtask

   task automatic checkAll();
      logic        eCyc, eStb, eWe, eAck;
      logic [3:0]  eSel;
      logic [25:0] eAdr;
      logic [31:0] eDat;
      logic [2:0]  eCti;
      eCyc = 0; eStb = 0; eWe = 0; eAck = 0; eSel = 0; eAdr = 0; eDat = 0; eCti = 0;
      if (owner == CORE_OWNS) begin
         eCyc = core_cyc; eStb = core_stb; eWe = core_we; eSel = core_sel;
         eAdr = core_adr - 26'(core_adr[1:0]); eDat = core_dat; eCti = core_cti;
         eAck = ram_ack;
      end else if (owner == LOADER_OWNS) begin
         eCyc = 1; eStb = 1; eWe = 1; eSel = pendSel; eAdr = pendAdr; eDat = pendDat;
      end
      checkOutput("ram_cyc", 32'(ram_cyc), 32'(eCyc));
      checkOutput("ram_stb", 32'(ram_stb), 32'(eStb));
      checkOutput("ram_we", 32'(ram_we), 32'(eWe));
      checkOutput("ram_sel", 32'(ram_sel), 32'(eSel));
      checkOutput("ram_adr", 32'(ram_adr), 32'(eAdr));
      checkOutput("ram_dat", ram_dat, eDat);
      checkOutput("ram_cti", 32'(ram_cti), 32'(eCti));
      checkOutput("core_ack", 32'(core_ack), 32'(eAck));
      checkOutput("ld_wait", 32'(ld_wait), 32'(pendValid));
      checkOutput("ld_ovf", 32'(ld_ovf), 32'(ovfSeen));
      checkOutput("timeout_err", 32'(timeout_err), 32'(abortPulse));
   endtask

   task automatic settle();
      @(negedge clk_sys);
      checkAll();
   endtask

   task automatic advance();
      @(posedge clk_sys);
      modelStep();
      #1;
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   task automatic waitForStb(input string tag, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         settle();
         if (ram_stb) seen = 1'b1;
         else advance();
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   task automatic clearInputs();
      core_cyc = 0; core_stb = 0; core_we = 0; core_sel = 4'hF; core_cti = 0;
      core_adr = 0; core_dat = 0; ld_active = 0; ld_wr = 0; ld_addr = 0;
      ld_data = 0; ram_ack = 0;
   endtask

   task automatic coreRequest(input logic [25:0] adr, input logic [2:0] cti, input logic we);
      core_cyc = 1; core_stb = 1; core_adr = adr; core_cti = cti; core_we = we;
      core_sel = 4'hF; core_dat = 32'hCAFEF00D;
   endtask

   task automatic applyStimulus(input int ackPct);
      if ($urandom_range(99) < 5) ld_active = !ld_active;
      ld_wr   = ($urandom_range(99) < 12);
      ld_addr = 25'($urandom);
      ld_data = 16'($urandom);
      if ($urandom_range(99) < 20) core_cyc = !core_cyc;
      core_stb = core_cyc && ($urandom_range(99) < 80);
      core_we  = 1'($urandom_range(1));
      core_sel = 4'($urandom);
      case ($urandom_range(2))
         0: core_cti = 3'b000;
         1: core_cti = 3'b010;
         default: core_cti = 3'b111;
      endcase
      core_adr = 26'($urandom);
      core_dat = $urandom;
      ram_ack  = ($urandom_range(99) < ackPct);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_time_limit: observed no finish expected finish");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      int edges;
      bit seen;
      clearInputs();
      reset_n = 0;
      modelReset();
      #2;
      checkAll();
      @(posedge clk_sys); #1;
      reset_n = 1;

      // Loader word into an empty register, then LOAD cycle with slow ack.
      ld_active = 1; ld_wr = 1; ld_addr = 25'h000006; ld_data = 16'hBEEF;
      cycle();
      ld_wr = 0;
      settle();
      checkOutput("t1_ld_wait", 32'(ld_wait), 32'd1);
      advance();
      waitForStb("t1_load_grant", 4);
      checkOutput("t1_adr", 32'(ram_adr), 32'h0400004);
      checkOutput("t1_sel", 32'(ram_sel), 32'hC);
      checkOutput("t1_dat", ram_dat, 32'hBEEFBEEF);
      checkOutput("t1_we", 32'(ram_we), 32'd1);
      advance();
      for (int i = 0; i < 4; i++) cycle();
      ram_ack = 1;
      cycle();
      ram_ack = 0;
      settle();
      checkOutput("t1_wait_release", 32'(ld_wait), 32'd0);
      checkOutput("t1_stb_idle", 32'(ram_stb), 32'd0);
      advance();
      ld_active = 0;

      // Core single read.
      coreRequest(26'h0001238, 3'b000, 1'b0);
      settle();
      checkOutput("t2_stb_before_grant", 32'(ram_stb), 32'd0);
      advance();
      ram_ack = 1;
      settle();
      checkOutput("t2_stb", 32'(ram_stb), 32'd1);
      checkOutput("t2_adr", 32'(ram_adr), 32'h0001238);
      checkOutput("t2_core_ack", 32'(core_ack), 32'd1);
      advance();
      ram_ack = 0;
      settle();
      checkOutput("t2_stb_after_ack", 32'(ram_stb), 32'd0);
      advance();
      core_cyc = 0; core_stb = 0;
      cycle();
      cycle();

      // Burst lock: loader word arrives on beat 2 but waits for end of burst.
      coreRequest(26'h0000100, 3'b010, 1'b0);
      cycle();
      for (int b = 0; b < 4; b++) begin
         core_cti = (b == 3) ? 3'b111 : 3'b010;
         core_adr = 26'h0000100 + 26'(4 * b);
         ram_ack  = 1;
         ld_wr    = (b == 1);
         ld_addr  = 25'h000010;
         ld_data  = 16'h1234;
         settle();
         checkOutput("t3_beat_ack", 32'(core_ack), 32'd1);
         checkOutput("t3_beat_adr", 32'(ram_adr), 32'h0000100 + 32'(4 * b));
         advance();
         ld_wr = 0;
      end
      core_cyc = 0; core_stb = 0; ram_ack = 0;
      waitForStb("t3_load_after_burst", 4);
      checkOutput("t3_load_adr", 32'(ram_adr), 32'h0400010);
      checkOutput("t3_load_sel", 32'(ram_sel), 32'h3);
      ram_ack = 1;
      advance();
      ram_ack = 0;

      // Full register beats a simultaneous core request.
      ld_wr = 1; ld_addr = 25'h000020; ld_data = 16'h5555;
      cycle();
      ld_wr = 0;
      coreRequest(26'h0002000, 3'b000, 1'b1);
      settle();
      checkOutput("t4_idle_stb", 32'(ram_stb), 32'd0);
      advance();
      ram_ack = 1;
      settle();
      checkOutput("t4_load_first", 32'(ram_adr), 32'h0400020);
      checkOutput("t4_load_dat", ram_dat, 32'h55555555);
      checkOutput("t4_no_core_ack", 32'(core_ack), 32'd0);
      advance();
      ram_ack = 0;
      cycle();
      ram_ack = 1;
      settle();
      checkOutput("t4_core_next", 32'(ram_adr), 32'h0002000);
      checkOutput("t4_core_ack", 32'(core_ack), 32'd1);
      advance();
      ram_ack = 0; core_cyc = 0; core_stb = 0;
      cycle();

      // Watchdog abort of a core read that never gets ram_ack.
      coreRequest(26'h0003000, 3'b000, 1'b0);
      cycle();
      edges = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         settle();
         if (timeout_err) seen = 1'b1;
         else begin advance(); edges++; end
      end
      checkOutput("t5_pulse_seen", 32'(seen), 32'd1);
      checkOutput("t5_latency", 32'(edges), 32'd16);
      checkOutput("t5_ram_cyc", 32'(ram_cyc), 32'd0);
      advance();
      waitForStb("t5_next_request", 4);
      ram_ack = 1;
      advance();
      ram_ack = 0; core_cyc = 0; core_stb = 0;
      cycle();

      // Overflow while full, then async reset in the middle of LOAD.
      ld_active = 1; ld_wr = 1; ld_addr = 25'h000040; ld_data = 16'h1111;
      cycle();
      ld_addr = 25'h000044; ld_data = 16'h2222;
      cycle();
      ld_addr = 25'h000048; ld_data = 16'h3333;
      settle();
      checkOutput("t6_ovf", 32'(ld_ovf), 32'd1);
      checkOutput("t6_first_word", ram_dat, 32'h11111111);
      advance();
      ld_wr = 0;
      settle();
      checkOutput("t6_still_first", ram_dat, 32'h11111111);
      reset_n = 0;
      #1;
      checkOutput("rst_ram_cyc", 32'(ram_cyc), 32'd0);
      checkOutput("rst_ram_stb", 32'(ram_stb), 32'd0);
      checkOutput("rst_ram_adr", 32'(ram_adr), 32'd0);
      checkOutput("rst_ram_dat", ram_dat, 32'd0);
      checkOutput("rst_ld_wait", 32'(ld_wait), 32'd0);
      checkOutput("rst_ld_ovf", 32'(ld_ovf), 32'd0);
      checkOutput("rst_core_ack", 32'(core_ack), 32'd0);
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
      modelReset();
      clearInputs();
      @(posedge clk_sys); #1;
      reset_n = 1;

      // Random traffic: normal acks, then rare acks to provoke aborts.
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(35);
         cycle();
      end
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(2);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single wishbone port of the SDRAM controller between two requesters: the Archimedes core memory master and the HPS ROM loader, which delivers 16-bit download words.
- Replaces the combinational download-select mux with a sequenced arbiter that has:
  - a one-entry loader holding register,
  - burst-aware grant locking,
  - a bus-timeout watchdog.
- Sits between archimedes_top, hps_io (ioctl) and sdram, in the clk_sys domain.

Parameters:
LOAD_BASE, 26'h0400000, byte address added to loader addresses (ROM region).
TIMEOUT, 1023, clk_sys cycles without ram_ack before a granted cycle is aborted.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
core_cyc  in  1  core wishbone cycle.
core_stb  in  1  core strobe.
core_we  in  1  core write enable.
core_sel  in  4  core byte selects.
core_cti  in  3  core cycle type (000 classic, 010 incrementing burst, 111 end-of-burst).
core_adr  in  26  core byte address; bits [1:0] ignored.
core_dat  in  32  core write data.
core_ack  out  1  ack to core.
ld_active  in  1  ROM download in progress (ioctl_download & index==1).
ld_wr  in  1  single-cycle loader word strobe.
ld_addr  in  25  loader byte address.
ld_data  in  16  loader word.
ld_wait  out  1  loader back-pressure (to ioctl_wait).
ld_ovf  out  1  sticky: ld_wr received while the holding register was full.
ram_cyc  out  1  SDRAM wishbone cycle.
ram_stb  out  1  SDRAM wishbone strobe.
ram_we  out  1  SDRAM wishbone write enable.
ram_sel  out  4  SDRAM byte selects.
ram_adr  out  26  SDRAM byte address.
ram_dat  out  32  SDRAM write data.
ram_cti  out  3  SDRAM cycle type.
ram_ack  in  1  ack from SDRAM.
timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, reset_n low):
  - state IDLE; holding register empty.
  - All outputs 0, including ld_ovf, ld_wait, core_ack, ram_* and timeout_err.
  - Watchdog counter cleared.
  - A cycle in flight is abandoned with no ack issued.
- States: IDLE, CORE, LOAD.
- Loader capture:
  - ld_wr with holding register empty: register captures
    - adr = LOAD_BASE + {ld_addr[23:2],2'b00},
    - sel = ld_addr[1] ? 4'b1100 : 4'b0011,
    - dat = {ld_data,ld_data}, we = 1, cti = 000.
  - ld_wait goes high on the next edge and stays high until the edge after the loader ram_ack.
  - ld_wr with the register full: word dropped, ld_ovf set (cleared only by reset).
- IDLE grant, evaluated each cycle with the following priority:
  - holding register full -> LOAD.
  - else core_cyc & core_stb & !ld_active -> CORE.
  - else stay in IDLE.
  - Grant takes effect on the next edge, so core request-to-ram_stb latency is 1 cycle.
- CORE:
  - ram_* driven combinationally from core_*, with ram_adr = {core_adr[25:2],2'b00}.
  - core_ack = ram_ack.
  - Grant is held through a burst (cti 010) even if a loader word arrives.
  - Exit to IDLE on any of:
    - ram_ack with core_cti 000 or 111,
    - core_cyc dropping (no ack forwarded afterwards).
- LOAD:
  - ram_cyc = ram_stb = 1, other ram_* from the holding register.
  - core_ack = 0.
  - On ram_ack: register emptied, next state IDLE.
- While ld_active:
  - core requests are never granted; core_ack stays 0.
  - The core is held in reset externally.
- ld_active falling with the register full: the pending write still completes.
- Watchdog:
  - Counter increments in CORE and LOAD, clears on ram_ack and in IDLE.
  - On reaching TIMEOUT: timeout_err pulses, state returns to IDLE, ram_cyc/ram_stb drop on that edge, and the holding register is emptied (ld_wait released).
  - No ack is ever generated by the arbiter itself.
- Simultaneous ld_wr and ram_ack ending a LOAD cycle:
  - capture uses the pre-edge full flag, so the word is dropped and ld_ovf is set.
  - The loader protocol forbids this case (ld_wait high).
- core_ack is never asserted outside CORE; ram_stb is never high in IDLE.

Test Plan:
1. Loader write: ld_active=1, ld_wr with ld_addr=0x000006, ld_data=0xBEEF -> next cycle ld_wait=1, ram_adr=0x0400004, ram_sel=1100, ram_dat=0xBEEFBEEF, ram_we=1; ram_ack 5 cycles later -> ld_wait=0 the edge after, state IDLE.
2. Core single read: core cti=000, adr=0x0001238 -> ram_stb 1 cycle later, ram_adr=0x0001238; ram_ack -> core_ack same cycle, ram_stb low the next cycle.
3. Burst lock: core 4-beat burst (010,010,010,111); loader ld_wr during beat 2 -> all four beats acked to the core first, then LOAD begins the cycle after the final ack.
4. Priority: holding register full and core requesting in the same IDLE cycle, ld_active=0 -> LOAD granted first, core granted immediately after.
5. Timeout: TIMEOUT=16, core read with ram_ack held 0 -> timeout_err pulse 16 cycles after grant, ram_cyc=0, core_ack never asserted, next request accepted.
6. Overflow/reset: ld_wr twice while ld_wait=1 -> ld_ovf=1, second word absent on the ram bus; pulse reset_n low mid-LOAD -> all outputs 0 asynchronously, ld_ovf cleared.
